// File: rtl/noc_packet_depacketizer_pkg.sv
// Shared NoC definitions: flit types and the header layout
// used by both the packet creator and the depacketizer.
package noc_packet_depacketizer_pkg;

  typedef enum logic [1:0] {
    FLIT_HEADER      = 2'd0,
    FLIT_BODY        = 2'd1,
    FLIT_TAIL        = 2'd2,
    FLIT_HEADER_TAIL = 2'd3
  } flit_type_e;

  typedef enum logic {
    ST_IDLE,
    ST_PAYLOAD
  } depkt_state_e;

  localparam int unsigned DEF_FW      = 64;
  localparam int unsigned DEF_TDEST_W = 4;
  localparam int unsigned DEF_TID_W   = 4;
  localparam int unsigned DEF_SRC_W   = 8;

  // Header layout, LSB first: tdest, tid, last, tail_bytes, src_id
  function automatic int unsigned hdr_tid_off(
    input int unsigned dw
  );
    return dw;
  endfunction

  function automatic int unsigned hdr_last_off(
    input int unsigned dw,
    input int unsigned idw
  );
    return dw + idw;
  endfunction

  function automatic int unsigned hdr_tb_off(
    input int unsigned dw,
    input int unsigned idw
  );
    return dw + idw + 1;
  endfunction

  function automatic int unsigned hdr_tb_w(
    input int unsigned fw
  );
    return $clog2(fw / 8) + 1;
  endfunction

  function automatic int unsigned hdr_src_off(
    input int unsigned dw,
    input int unsigned idw,
    input int unsigned fw
  );
    return dw + idw + 1 + hdr_tb_w(fw);
  endfunction

  localparam int unsigned HDR_TDEST_OFF = 0;
  localparam int unsigned HDR_TID_OFF   = hdr_tid_off(DEF_TDEST_W);
  localparam int unsigned HDR_LAST_OFF  =
    hdr_last_off(DEF_TDEST_W, DEF_TID_W);
  localparam int unsigned HDR_TB_OFF    =
    hdr_tb_off(DEF_TDEST_W, DEF_TID_W);
  localparam int unsigned HDR_SRC_OFF   =
    hdr_src_off(DEF_TDEST_W, DEF_TID_W, DEF_FW);

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry beat FIFO; head register drives the outputs directly,
// and the not-full flag is registered so ready never sees out_ready.
module axis_skid_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  output logic             ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic [Width-1:0] slot1;
  logic [1:0]       count;
  logic [1:0]       count_nxt;
  logic             pop;
  logic             push_ok;

  assign pop     = out_valid & out_ready;
  assign push_ok = push & ((count != 2'd2) | pop);

  always_comb begin
    count_nxt = count + {1'b0, push_ok} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      out_valid <= 1'b0;
      ready     <= 1'b0;
      out_data  <= '0;
      slot1     <= '0;
    end else begin
      count     <= count_nxt;
      out_valid <= count_nxt != 2'd0;
      ready     <= count_nxt != 2'd2;
      if (pop) begin
        if (count == 2'd2) begin
          out_data <= slot1;
          if (push_ok) slot1 <= push_data;
        end else if (push_ok) begin
          out_data <= push_data;
        end
      end else if (push_ok) begin
        if (count == 2'd0) out_data <= push_data;
        else               slot1    <= push_data;
      end
    end
  end

endmodule

// File: rtl/noc_packet_depacketizer.sv
// Strips NoC header flits and rebuilds AXI-Stream beats,
// recovering tid/tdest/tkeep/tlast/tuser from the header.
module noc_packet_depacketizer
  import noc_packet_depacketizer_pkg::*;
#(
  parameter int unsigned NetworkIfFlitWidth             = DEF_FW,
  parameter int unsigned NetworkIfFlitTypeWidth         = 2,
  parameter int unsigned NetworkIfBroadcastWidth        = 1,
  parameter int unsigned NetworkIfVirtualChannelIdWidth = 1,
  parameter int unsigned AxiStreamIfTIdWidth            = DEF_TID_W,
  parameter int unsigned AxiStreamIfTDestWidth          = DEF_TDEST_W,
  parameter int unsigned NetworkIfSourceIdWidth         = DEF_SRC_W
) (
  input  logic clk_network_i,
  input  logic rst_network_i,
  input  logic network_valid_i,
  output logic network_ready_o,
  input  logic [NetworkIfFlitWidth-1:0] network_flit_i,
  input  logic [NetworkIfFlitTypeWidth-1:0] network_flit_type_i,
  input  logic [NetworkIfBroadcastWidth-1:0] network_broadcast_i,
  input  logic [NetworkIfVirtualChannelIdWidth-1:0]
    network_virtual_channel_id_i,
  output logic m_axis_tvalid_o,
  input  logic m_axis_tready_i,
  output logic [NetworkIfFlitWidth-1:0] m_axis_tdata_o,
  output logic [NetworkIfFlitWidth/8-1:0] m_axis_tkeep_o,
  output logic m_axis_tlast_o,
  output logic [AxiStreamIfTIdWidth-1:0] m_axis_tid_o,
  output logic [AxiStreamIfTDestWidth-1:0] m_axis_tdest_o,
  output logic [NetworkIfSourceIdWidth-1:0] m_axis_tuser_o,
  output logic protocol_error_o
);

  localparam int unsigned FW       = NetworkIfFlitWidth;
  localparam int unsigned NB       = FW / 8;
  localparam int unsigned IDW      = AxiStreamIfTIdWidth;
  localparam int unsigned DW       = AxiStreamIfTDestWidth;
  localparam int unsigned SIDW     = NetworkIfSourceIdWidth;
  localparam int unsigned TBW      = hdr_tb_w(FW);
  localparam int unsigned TID_OFF  = hdr_tid_off(DW);
  localparam int unsigned LAST_OFF = hdr_last_off(DW, IDW);
  localparam int unsigned TB_OFF   = hdr_tb_off(DW, IDW);
  localparam int unsigned SRC_OFF  = hdr_src_off(DW, IDW, FW);
  localparam int unsigned BEAT_W   = FW + NB + 1 + IDW + DW + SIDW;

  depkt_state_e state;
  flit_type_e   ft;

  logic            acc;
  logic            in_pay;
  logic [DW-1:0]   h_tdest;
  logic [IDW-1:0]  h_tid;
  logic            h_last;
  logic [TBW-1:0]  h_tb;
  logic [SIDW-1:0] h_src;

  logic [DW-1:0]   lat_tdest;
  logic [IDW-1:0]  lat_tid;
  logic            lat_last;
  logic [TBW-1:0]  lat_tb;
  logic [SIDW-1:0] lat_src;

  logic [TBW-1:0]  tb_eff;
  logic [NB-1:0]   tail_keep;

  logic            push;
  logic            err;
  logic [FW-1:0]   b_data;
  logic [NB-1:0]   b_keep;
  logic            b_last;
  logic [IDW-1:0]  b_tid;
  logic [DW-1:0]   b_tdest;
  logic [SIDW-1:0] b_user;
  logic [BEAT_W-1:0] beat_in;
  logic [BEAT_W-1:0] beat_out;
  logic            unused_inputs;

  assign unused_inputs = ^{network_broadcast_i,
                           network_virtual_channel_id_i};

  assign ft      = flit_type_e'(network_flit_type_i[1:0]);
  assign acc     = network_valid_i & network_ready_o;
  assign in_pay  = state == ST_PAYLOAD;
  assign h_tdest = network_flit_i[0 +: DW];
  assign h_tid   = network_flit_i[TID_OFF +: IDW];
  assign h_last  = network_flit_i[LAST_OFF];
  assign h_tb    = network_flit_i[TB_OFF +: TBW];
  assign h_src   = network_flit_i[SRC_OFF +: SIDW];

  // Out-of-range tail_bytes means a full flit
  always_comb begin
    tb_eff = lat_tb;
    if (lat_tb == '0 || lat_tb > TBW'(NB)) tb_eff = TBW'(NB);
    for (int i = 0; i < NB; i++) begin
      tail_keep[i] = TBW'(i) < tb_eff;
    end
  end

  always_comb begin
    push    = 1'b0;
    err     = 1'b0;
    b_data  = network_flit_i;
    b_keep  = '1;
    b_last  = 1'b0;
    b_tid   = lat_tid;
    b_tdest = lat_tdest;
    b_user  = lat_src;
    unique case (ft)
      FLIT_HEADER: err = in_pay;
      FLIT_HEADER_TAIL: begin
        err     = in_pay;
        push    = h_last;
        b_data  = '0;
        b_keep  = '0;
        b_last  = 1'b1;
        b_tid   = h_tid;
        b_tdest = h_tdest;
        b_user  = h_src;
      end
      FLIT_BODY: begin
        push = in_pay;
        err  = !in_pay;
      end
      FLIT_TAIL: begin
        push   = in_pay;
        err    = !in_pay;
        b_keep = tail_keep;
        b_last = lat_last;
      end
      default: ;
    endcase
    push = push & acc;
    err  = err & acc;
  end

  always_ff @(posedge clk_network_i) begin
    if (rst_network_i) begin
      state            <= ST_IDLE;
      lat_tdest        <= '0;
      lat_tid          <= '0;
      lat_last         <= 1'b0;
      lat_tb           <= '0;
      lat_src          <= '0;
      protocol_error_o <= 1'b0;
    end else begin
      protocol_error_o <= err;
      if (acc) begin
        unique case (ft)
          FLIT_HEADER, FLIT_HEADER_TAIL: begin
            lat_tdest <= h_tdest;
            lat_tid   <= h_tid;
            lat_last  <= h_last;
            lat_tb    <= h_tb;
            lat_src   <= h_src;
            state     <= (ft == FLIT_HEADER) ? ST_PAYLOAD : ST_IDLE;
          end
          FLIT_TAIL: if (in_pay) state <= ST_IDLE;
          default: ;
        endcase
      end
    end
  end

  assign beat_in = {b_data, b_keep, b_last, b_tid, b_tdest, b_user};

  axis_skid_fifo2 #(
    .Width(BEAT_W)
  ) u_fifo (
    .clk      (clk_network_i),
    .rst      (rst_network_i),
    .push     (push),
    .push_data(beat_in),
    .ready    (network_ready_o),
    .out_valid(m_axis_tvalid_o),
    .out_ready(m_axis_tready_i),
    .out_data (beat_out)
  );

  assign {m_axis_tdata_o, m_axis_tkeep_o, m_axis_tlast_o,
          m_axis_tid_o, m_axis_tdest_o, m_axis_tuser_o} = beat_out;

endmodule

// File: tb/tb_noc_packet_depacketizer.sv
// Scoreboard bench for noc_packet_depacketizer: directed packets,
// stalls, protocol errors, reset mid-packet and a random mix.
module tb_noc_packet_depacketizer;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [3:0]  id;
    logic [3:0]  de;
    logic [7:0]  u;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nvalid = 1'b0;
  logic        nready;
  logic [63:0] flit = '0;
  logic [1:0]  ftype = '0;
  logic [0:0]  bcast = '0;
  logic [0:0]  vc = '0;
  logic        tvalid;
  logic        tready = 1'b0;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic [3:0]  tid;
  logic [3:0]  tdest;
  logic [7:0]  tuser;
  logic        perr;

  beat_t sbq[$];
  int    errors = 0;
  int    checks = 0;
  int    perr_count = 0;
  bit    rnd_ready = 1'b0;
  bit    ready_val = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;

  noc_packet_depacketizer dut (
    .clk_network_i               (clk),
    .rst_network_i               (rst),
    .network_valid_i             (nvalid),
    .network_ready_o             (nready),
    .network_flit_i              (flit),
    .network_flit_type_i         (ftype),
    .network_broadcast_i         (bcast),
    .network_virtual_channel_id_i(vc),
    .m_axis_tvalid_o             (tvalid),
    .m_axis_tready_i             (tready),
    .m_axis_tdata_o              (tdata),
    .m_axis_tkeep_o              (tkeep),
    .m_axis_tlast_o              (tlast),
    .m_axis_tid_o                (tid),
    .m_axis_tdest_o              (tdest),
    .m_axis_tuser_o              (tuser),
    .protocol_error_o            (perr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    tready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_val;
  end

  task automatic chk(input string name,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic [63:0] d,
                               input logic [7:0] k,
                               input logic l,
                               input logic [3:0] id,
                               input logic [3:0] de,
                               input logic [7:0] u);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    b.id = id; b.de = de; b.u = u;
    return b;
  endfunction

  function automatic logic [63:0] hdr(input logic [3:0] id,
                                      input logic [3:0] de,
                                      input logic last,
                                      input logic [3:0] tb,
                                      input logic [7:0] src);
    return {43'd0, src, tb, last, id, de};
  endfunction

  // Monitor: pops the scoreboard on each handshake, checks stalls
  always @(negedge clk) begin
    beat_t cur;
    beat_t exp;
    cur = {tdata, tkeep, tlast, tid, tdest, tuser};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (perr) perr_count++;
      if (prev_stall)
        chk("stall_stable", 128'({tvalid, cur}),
            128'({1'b1, prev_beat}));
      if (tvalid && tready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", 128'(cur), 128'(0));
        end else begin
          exp = sbq.pop_front();
          chk("beat", 128'(cur), 128'(exp));
        end
      end
      prev_stall = tvalid && !tready;
      prev_beat  = cur;
    end
  end

  task automatic send(input logic [1:0] ft,
                      input logic [63:0] d,
                      input bit exp_err,
                      input bit chk_lat);
    int n = 0;
    @(negedge clk);
    nvalid = 1'b1;
    ftype  = ft;
    flit   = d;
    while (!nready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!nready) begin
      chk("accept_timeout", 128'(0), 128'(1));
      nvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    nvalid = 1'b0;
    chk("perr", 128'(perr), 128'(exp_err));
    if (chk_lat)
      chk("latency", 128'({tvalid, tdata}), 128'({1'b1, d}));
  endtask

  task automatic packet(input logic [3:0] id,
                        input logic [3:0] de,
                        input logic last,
                        input logic [3:0] tb,
                        input logic [7:0] src,
                        input int nbody,
                        input bit chk_lat,
                        input bit hdr_err);
    logic [63:0] d;
    logic [7:0]  tk;
    send(2'd0, hdr(id, de, last, tb, src), hdr_err, 1'b0);
    for (int i = 0; i < nbody; i++) begin
      d = {$urandom(), $urandom()};
      sbq.push_back(mk(d, 8'hFF, 1'b0, id, de, src));
      send(2'd1, d, 1'b0, chk_lat);
    end
    if (tb == 4'd0 || tb > 4'd8) tk = 8'hFF;
    else tk = 8'((16'd1 << tb) - 16'd1);
    d = {$urandom(), $urandom()};
    sbq.push_back(mk(d, tk, last, id, de, src));
    send(2'd2, d, 1'b0, chk_lat);
  endtask

  initial begin
    int c;
    int n;
    logic [63:0] d;
    // Reset state and ready release timing
    repeat (3) @(negedge clk);
    chk("reset_outs",
        128'({tvalid, tdata, tkeep, tlast, tid, tdest, tuser,
              perr, nready}), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_val = 1'b1;
    @(negedge clk);
    chk("ready_after_rst_same", 128'(nready), 128'(0));
    @(negedge clk);
    chk("ready_after_rst_next", 128'(nready), 128'(1));

    // Basic packet with per-beat latency check
    packet(4'd3, 4'd5, 1'b1, 4'd3, 8'h12, 2, 1'b1, 1'b0);

    // Backpressure: FIFO fills after two payload flits
    ready_val = 1'b0;
    send(2'd0, hdr(4'd3, 4'd5, 1'b1, 4'd3, 8'h12), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      d = 64'h1111_2222_3333_4444 * 64'(i + 1);
      sbq.push_back(mk(d, 8'hFF, 1'b0, 4'd3, 4'd5, 8'h12));
      send(2'd1, d, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("ready_full", 128'(nready), 128'(0));
    repeat (9) @(negedge clk);
    ready_val = 1'b1;
    d = 64'hDEAD_BEEF_CAFE_F00D;
    sbq.push_back(mk(d, 8'h07, 1'b1, 4'd3, 4'd5, 8'h12));
    send(2'd2, d, 1'b0, 1'b0);

    // header_tail: null beat only when last=1
    sbq.push_back(mk(64'd0, 8'h00, 1'b1, 4'd6, 4'd2, 8'h44));
    send(2'd3, hdr(4'd6, 4'd2, 1'b1, 4'd8, 8'h44), 1'b0, 1'b0);
    send(2'd3, hdr(4'd7, 4'd1, 1'b0, 4'd8, 8'h45), 1'b0, 1'b0);

    // Payload flits in IDLE are dropped with one error pulse
    c = perr_count;
    send(2'd1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("perr_once", 128'(perr_count), 128'(c + 1));
    send(2'd2, 64'h0BAD_0BAD_0BAD_0BAD, 1'b1, 1'b0);

    // Header mid-packet restarts with the new tid
    send(2'd0, hdr(4'd1, 4'd4, 1'b0, 4'd2, 8'h20), 1'b0, 1'b0);
    d = 64'hAAAA_5555_AAAA_5555;
    sbq.push_back(mk(d, 8'hFF, 1'b0, 4'd1, 4'd4, 8'h20));
    send(2'd1, d, 1'b0, 1'b0);
    packet(4'd9, 4'd7, 1'b1, 4'd8, 8'h33, 1, 1'b0, 1'b1);

    // Reset with two beats queued discards everything
    repeat (4) @(negedge clk);
    ready_val = 1'b0;
    send(2'd0, hdr(4'd2, 4'd2, 1'b1, 4'd1, 8'h01), 1'b0, 1'b0);
    send(2'd1, 64'h1, 1'b0, 1'b0);
    send(2'd1, 64'h2, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_full", 128'({tvalid, nready}), 128'(2'b10));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_outs",
        128'({tvalid, tdata, tkeep, tlast, tid, tdest, tuser,
              perr, nready}), 128'(0));
    rst = 1'b0;
    ready_val = 1'b1;
    packet(4'd4, 4'd8, 1'b0, 4'd0, 8'h99, 2, 1'b0, 1'b0);

    // Random back-to-back packets with random ready
    rnd_ready = 1'b1;
    for (int p = 0; p < 15; p++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [3:0] rid;
        logic [3:0] rde;
        logic [7:0] rsrc;
        logic       rl;
        rid  = 4'($urandom_range(0, 15));
        rde  = 4'($urandom_range(0, 15));
        rsrc = 8'($urandom_range(0, 255));
        rl   = 1'($urandom_range(0, 1));
        if (rl) sbq.push_back(mk(64'd0, 8'h00, 1'b1, rid, rde, rsrc));
        send(2'd3, hdr(rid, rde, rl, 4'd1, rsrc), 1'b0, 1'b0);
      end else begin
        packet(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               8'($urandom_range(0, 255)), $urandom_range(0, 3),
               1'b0, 1'b0);
      end
    end

    // Drain and confirm nothing is left outstanding
    rnd_ready = 1'b0;
    ready_val = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_empty", 128'(sbq.size()), 128'(0));
    chk("tvalid_idle", 128'(tvalid), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
